// File: rtl/dcp_word_tx.sv
// Word-to-ASCII byte transmitter for the debug command processor.
// Prints a single character or an 8-digit hex word, one request at a time, over a valid/ready byte channel.
module dcp_word_tx #(
    parameter logic HEX_UPPER = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_tx,
    input  logic        type_tx,
    input  logic [31:0] dout_tx,
    output logic        ack_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx,
    output logic [1:0]  dbg_state_o
);

    // Byte channel: a byte moves on every rising clk edge where vld_tx & rdy_tx.
    // vld_tx and d_tx are registered; once vld_tx is high it stays high with d_tx
    // unchanged until that handshake happens (only reset can drop it early).

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [7:0]  d_q,     d_d;
    logic        vld_q,   vld_d;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = 8'h30 + {4'h0, n};
        end else if (HEX_UPPER) begin
            r = 8'h41 + {4'h0, n - 4'd10};
        end else begin
            r = 8'h61 + {4'h0, n - 4'd10};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            shift_q <= 32'h0;
            cnt_q   <= 3'd0;
            d_q     <= 8'h00;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        vld_d   = vld_q;
        case (state_q)
            S_IDLE: begin
                if (req_tx) begin
                    // The digit count remembers the request type: 7 more digits follow for a word.
                    shift_d = dout_tx;
                    cnt_d   = type_tx ? 3'd7 : 3'd0;
                    d_d     = type_tx ? nib_to_ascii(dout_tx[31:28]) : dout_tx[7:0];
                    vld_d   = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (vld_q && rdy_tx) begin
                    if (cnt_q == 3'd0) begin
                        vld_d   = 1'b0;
                        state_d = S_ACK;
                    end else begin
                        shift_d = {shift_q[27:0], 4'h0};
                        cnt_d   = cnt_q - 3'd1;
                        d_d     = nib_to_ascii(shift_q[27:24]);
                    end
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // A level request still held high must not print a second time.
                if (!req_tx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack_tx      = (state_q == S_ACK);
    assign d_tx        = d_q;
    assign vld_tx      = vld_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dcp_word_tx.sv
// Bench for dcp_word_tx: directed prints on an upper-case and a lower-case instance,
// checked every cycle against an expected-byte queue built from the ASCII rules.
module tb_dcp_word_tx;

  logic        clk;
  logic        rstn;
  logic        type_tx;
  logic [31:0] dout_tx;
  logic        rdy_tx;
  logic        req_u, req_l;
  logic        ack_u, ack_l;
  logic        vld_u, vld_l;
  logic [7:0]  d_u, d_l;
  logic [1:0]  st_u, st_l;

  dcp_word_tx #(.HEX_UPPER(1'b1)) dut_u (
    .clk(clk), .rstn(rstn), .req_tx(req_u), .type_tx(type_tx), .dout_tx(dout_tx),
    .ack_tx(ack_u), .d_tx(d_u), .vld_tx(vld_u), .rdy_tx(rdy_tx), .dbg_state_o(st_u)
  );

  dcp_word_tx #(.HEX_UPPER(1'b0)) dut_l (
    .clk(clk), .rstn(rstn), .req_tx(req_l), .type_tx(type_tx), .dout_tx(dout_tx),
    .ack_tx(ack_l), .d_tx(d_l), .vld_tx(vld_l), .rdy_tx(rdy_tx), .dbg_state_o(st_l)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       sel = 1'b0;      // 0: dut_u active, 1: dut_l active
  logic       rdy_rand = 1'b0;
  logic       pend_ack = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] stall_d = 8'h00;
  int         hs_cnt = 0;
  int         ack_cnt = 0;
  logic [7:0] mb[8];
  int         mn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [7:0] asc(input logic [3:0] n, input logic upper);
    int v;
    v = int'(n);
    if (v < 10) return 8'(48 + v);
    if (upper) return 8'(65 + v - 10);
    return 8'(97 + v - 10);
  endfunction

  task automatic build_model(input logic t, input logic [31:0] w, input logic upper);
    if (!t) begin
      mb[0] = w[7:0];
      mn = 1;
    end else begin
      for (int i = 0; i < 8; i++) begin
        mb[i] = asc(4'((w >> (28 - 4 * i)) & 32'hF), upper);
      end
      mn = 8;
    end
  endtask

  task automatic pin_seq(input string nm, input logic [7:0] lit[8]);
    for (int i = 0; i < 8; i++) chk(nm, {24'h0, mb[i]}, {24'h0, lit[i]});
  endtask

  // ---------------- ready driver ----------------
  initial begin
    rdy_tx = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rdy_tx = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic       mvld, mack, ovld;
    logic [7:0] md, e;
    mvld = sel ? vld_l : vld_u;
    mack = sel ? ack_l : ack_u;
    md   = sel ? d_l : d_u;
    ovld = sel ? vld_u : vld_l;
    if (!rstn) begin
      chk("rst_vld_u", {31'h0, vld_u}, 32'h0);
      chk("rst_ack_u", {31'h0, ack_u}, 32'h0);
      chk("rst_d_u", {24'h0, d_u}, 32'h0);
      chk("rst_vld_l", {31'h0, vld_l}, 32'h0);
      exp_q.delete();
      pend_ack = 1'b0;
      stall = 1'b0;
    end else begin
      chk("other_dut_quiet", {31'h0, ovld}, 32'h0);
      if (pend_ack) begin
        chk("ack_pulse", {31'h0, mack}, 32'h1);
        chk("ack_vld_low", {31'h0, mvld}, 32'h0);
        pend_ack = 1'b0;
      end else begin
        chk("ack_quiet", {31'h0, mack}, 32'h0);
      end
      if (stall) begin
        chk("stall_vld", {31'h0, mvld}, 32'h1);
        chk("stall_d", {24'h0, md}, {24'h0, stall_d});
      end
      if (mvld && rdy_tx) begin
        if (exp_q.size() == 0) begin
          chk("spurious_byte", {24'h0, md}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {24'h0, md}, {24'h0, e});
          hs_cnt++;
          if (exp_q.size() == 0) pend_ack = 1'b1;
        end
      end
      stall   = mvld && !rdy_tx;
      stall_d = md;
      if (mack) ack_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input logic s, input logic [7:0] first, input logic chg);
    logic got;
    tick();
    chk("first_vld", {31'h0, (s ? vld_l : vld_u)}, 32'h1);
    chk("first_d", {24'h0, (s ? d_l : d_u)}, {24'h0, first});
    if (chg) dout_tx = 32'h1111_1111;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (s ? ack_l : ack_u) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("ack_timeout", {31'h0, got}, 32'h1);
  endtask

  task automatic print(input logic s, input logic t, input logic [31:0] w,
                       input logic hold, input logic chg);
    int a0;
    sel = s;
    a0 = ack_cnt;
    build_model(t, w, !s);
    for (int i = 0; i < mn; i++) exp_q.push_back(mb[i]);
    type_tx = t;
    dout_tx = w;
    if (s) req_l = 1'b1; else req_u = 1'b1;
    wait_done(s, mb[0], chg);
    if (hold) repeat (10) tick();
    req_u = 1'b0;
    req_l = 1'b0;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'h0);
    chk("ack_count", ack_cnt - a0, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] lit[8];
    int a0;
    logic ok;
    rstn = 1'b1;
    req_u = 1'b0;
    req_l = 1'b0;
    type_tx = 1'b0;
    dout_tx = 32'h0;

    // model pins
    chk("pin_asc_A", {24'h0, asc(4'hA, 1'b1)}, 32'h41);
    chk("pin_asc_f", {24'h0, asc(4'hF, 1'b0)}, 32'h66);
    chk("pin_asc_9", {24'h0, asc(4'h9, 1'b1)}, 32'h39);

    // reset with a request already held high
    #2 rstn = 1'b0;
    req_u = 1'b1;
    type_tx = 1'b0;
    dout_tx = 32'h0000_0041;
    repeat (3) tick();
    chk("rst_hold_vld", {31'h0, vld_u}, 32'h0);
    chk("rst_hold_d", {24'h0, d_u}, 32'h0);
    chk("rst_hold_state", {30'h0, st_u}, 32'h0);
    a0 = ack_cnt;
    exp_q.push_back(8'h41);
    rstn = 1'b1;
    wait_done(1'b0, 8'h41, 1'b0);
    req_u = 1'b0;
    repeat (3) tick();
    chk("rst_print_ack", ack_cnt - a0, 32'h1);

    // hex word, request held past ack
    build_model(1'b1, 32'h1234_ABCD, 1'b1);
    lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
    pin_seq("pin_1234abcd", lit);
    print(1'b0, 1'b1, 32'h1234_ABCD, 1'b1, 1'b0);

    // single character, then all-zero word
    print(1'b0, 1'b0, 32'h0000_000D, 1'b0, 1'b0);
    build_model(1'b1, 32'h0, 1'b1);
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};
    pin_seq("pin_zero", lit);
    print(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    print(1'b0, 1'b0, 32'hFFFF_FF00, 1'b0, 1'b0);

    // random back-pressure
    build_model(1'b1, 32'hDEAD_BEEF, 1'b1);
    lit = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
    pin_seq("pin_deadbeef", lit);
    hs_cnt = 0;
    rdy_rand = 1'b1;
    print(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    rdy_rand = 1'b0;
    tick();
    chk("deadbeef_handshakes", hs_cnt, 32'd8);

    // lower-case instance, input changed after acceptance
    build_model(1'b1, 32'hFACE_0000, 1'b0);
    lit = '{8'h66, 8'h61, 8'h63, 8'h65, 8'h30, 8'h30, 8'h30, 8'h30};
    pin_seq("pin_face", lit);
    print(1'b1, 1'b1, 32'hFACE_0000, 1'b0, 1'b1);

    // reset after the third handshake of a word
    sel = 1'b0;
    hs_cnt = 0;
    build_model(1'b1, 32'h9876_5432, 1'b1);
    for (int i = 0; i < mn; i++) exp_q.push_back(mb[i]);
    type_tx = 1'b1;
    dout_tx = 32'h9876_5432;
    req_u = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (hs_cnt >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reset_reach", {31'h0, ok}, 32'h1);
    tick();
    rstn = 1'b0;
    #1;
    chk("mid_reset_vld", {31'h0, vld_u}, 32'h0);
    chk("mid_reset_ack", {31'h0, ack_u}, 32'h0);
    req_u = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();
    build_model(1'b1, 32'h0000_0001, 1'b1);
    lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31};
    pin_seq("pin_one", lit);
    print(1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcp_word_tx.md
# dcp_word_tx

Byte-stream transmitter for the debug command processor: turns word-level print requests from the DCP command children into ASCII characters on the UART-side transmit byte channel. It is the output-side counterpart of the character-to-word scanner. It serves the single-character prints (prompts, separators, CR/LF) and the 8-digit hexadecimal dumps (PC, IR, registers, memory words). One request in flight at a time; all DCP children share it through the DCP mux.

## Interface
Parameters:
- HEX_UPPER, 1, 1: hex digits 10-15 print as 'A'-'F' (0x41-0x46); 0: 'a'-'f' (0x61-0x66)

Ports:
- clk  in  1  system clock; the only clock
- rstn  in  1  reset, asynchronous, active-low
- req_tx  in  1  print request, level, held by requester until ack_tx
- type_tx  in  1  0: single character dout_tx[7:0]; 1: 8 hex digits of dout_tx, MSB nibble first
- dout_tx  in  32  word/character to print, captured on acceptance
- ack_tx  out  1  one-cycle pulse: request fully transmitted
- d_tx  out  8  ASCII byte to transmitter
- vld_tx  out  1  d_tx valid
- rdy_tx  in  1  transmitter accepts d_tx when vld_tx & rdy_tx

## Operation
- States: IDLE, SEND, ACK, RELEASE.
- IDLE: if req_tx=1, capture dout_tx into shift register, capture type_tx, load digit counter (7 for type 1, 0 for type 0), load d_tx with first char, set vld_tx=1, go SEND.
- First char: type 0 → dout_tx[7:0] verbatim; type 1 → ASCII of dout_tx[31:28].
- Nibble→ASCII: 0-9 → 0x30+n; 10-15 → 0x41+(n-10) (HEX_UPPER=1) or 0x61+(n-10).
- SEND, on vld_tx & rdy_tx: if counter=0, clear vld_tx, go ACK. Otherwise shift register left 4, decrement counter, load d_tx with ASCII of the new top nibble, keep vld_tx=1 (back-to-back).
- SEND with rdy_tx=0: hold d_tx, vld_tx, counter, and shift register unchanged.
- ACK: ack_tx=1 for this one cycle; go RELEASE.
- RELEASE: wait for req_tx=0, then go IDLE. This prevents a still-held level request from re-printing.
- req_tx or dout_tx/type_tx changing after capture: ignored until RELEASE; the transfer completes with the captured values.
- req_tx deasserted mid-SEND: transfer still completes; ack_tx still pulses; RELEASE passes through in one cycle.
- Type 0 with dout_tx[7:0]=0x00 is transmitted as a normal byte.

## Timing
- Reset (async assert, sync-released by clk edges): state=IDLE, vld_tx=0, d_tx=0x00, ack_tx=0, counter=0, shift register=0. Reset mid-SEND drops vld_tx immediately; the partial output is abandoned.
- Latency: req_tx sampled high at edge n → vld_tx=1 with first char after edge n.
- With rdy_tx held 1: type 1 takes 8 handshake cycles, type 0 takes 1.
- ack_tx is high in the cycle after the last handshake edge; vld_tx is already 0 in that cycle.
- Earliest next acceptance: one cycle after req_tx is seen low in RELEASE.
- d_tx is registered and changes only on a handshake edge or on acceptance; no combinational path from rdy_tx to d_tx or vld_tx.
- Protocol: vld_tx never drops without a handshake, except at reset.

## Test plan
- Reset with req_tx=1 held: during and after reset, vld_tx=0, ack_tx=0, d_tx=0x00. After release, first char appears one cycle later.
- type_tx=1, dout_tx=0x1234ABCD, rdy_tx=1, HEX_UPPER=1 → 8 consecutive bytes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44, then ack_tx pulses once. No second print while req_tx stays high; a new print starts only after a low→high req_tx.
- type_tx=0, dout_tx=0x0000000D → single byte 0x0D, ack one cycle after the handshake. Then type 1, 0x00000000 → eight 0x30 bytes.
- type_tx=1, 0xDEADBEEF, rdy_tx toggling randomly (50%) → d_tx stable while vld_tx=1 & rdy_tx=0. Sequence is 0x44 0x45 0x41 0x44 0x42 0x45 0x45 0x46; exactly 8 handshakes.
- HEX_UPPER=0, 0xFACE0000 → 0x66 0x61 0x63 0x65 0x30 0x30 0x30 0x30. Additionally, change dout_tx to 0x11111111 after acceptance → output unchanged.
- Assert rstn=0 after the 3rd handshake of a type 1 print → vld_tx=0 at once. Then issue a fresh request 0x00000001 → clean "00000001" with a single ack_tx.
